// File: rtl/maple_pkg.sv
// Shared definitions for the Maple bus receive path.
// Holds the INCTRL bit positions, the receiver state encoding and the
// start/end pulse counts. maple_out and the driver headers use the same values.
package maple_pkg;

    // INCTRL write bits
    localparam int unsigned INCTRL_ARM   = 0;
    localparam int unsigned INCTRL_ABORT = 1;

    // INCTRL read bits
    localparam int unsigned INCTRL_ARMED = 0;
    localparam int unsigned INCTRL_BUSY  = 1;
    localparam int unsigned INCTRL_DONE  = 2;
    localparam int unsigned INCTRL_ERR   = 3;
    localparam int unsigned INCTRL_OVF   = 4;

    localparam logic [7:0] TIMEOUT_TICKS_DEF = 8'd200;

    // SDCKB falls inside a valid start pattern, SDCKA falls inside a valid end pattern
    localparam logic [2:0] START_PULSES = 3'd4;
    localparam logic [1:0] END_PULSES   = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_START = 3'd1,
        ST_START      = 3'd2,
        ST_DATA_A     = 3'd3,
        ST_DATA_B     = 3'd4,
        ST_END        = 3'd5
    } maple_state_e;

    // States in which a frame is actively being received
    function automatic logic state_is_busy(input maple_state_e s);
        return (s == ST_START) || (s == ST_DATA_A) || (s == ST_DATA_B) || (s == ST_END);
    endfunction

endpackage

// File: rtl/maple_line_sync.sv
// Two-flop synchroniser for one Maple line, plus single-cycle rise/fall pulses.
// Flops reset high to match an idle bus, so release from reset gives no edge.
module maple_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronise the pin and keep one delayed copy for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;
    assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/maple_in.sv
// Maple bus receiver: decodes SDCKA/SDCKB frames into bytes for the read FIFO.
//
// state         | meaning
// --------------+-----------------------------------------------------------
// ST_IDLE       | inert, waiting for ARM
// ST_WAIT_START | armed, waiting for SDCKA fall with SDCKB high
// ST_START      | counting SDCKB falls while SDCKA low
// ST_DATA_A     | SDCKA fall samples SDCKB; SDCKB fall with SDCKA high = end
// ST_DATA_B     | SDCKB fall samples SDCKA
// ST_END        | counting SDCKA falls while SDCKB low until SDCKB rises
module maple_in
    import maple_pkg::*;
#(
    parameter logic [7:0] TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       in_p1,
    input  logic       in_p5,
    input  logic       cs,
    input  logic       we,
    output logic [7:0] regdata_read,
    input  logic [7:0] regdata_write,
    output logic [7:0] fifo_data,
    output logic       fifo_we,
    input  logic [7:0] fifo_free,
    output logic       rx_done
);

    logic a_level, a_rise, a_fall;
    logic b_level, b_rise, b_fall;

    maple_line_sync u_sync_a (
        .clk    (clk),
        .rst    (rst),
        .line_i (in_p1),
        .level_o(a_level),
        .rise_o (a_rise),
        .fall_o (a_fall)
    );

    maple_line_sync u_sync_b (
        .clk    (clk),
        .rst    (rst),
        .line_i (in_p5),
        .level_o(b_level),
        .rise_o (b_rise),
        .fall_o (b_fall)
    );

    maple_state_e state_q;
    logic [2:0]   startcnt_q;
    logic [1:0]   endcnt_q;
    logic [2:0]   bitcnt_q;
    logic [7:0]   shift_q;
    logic [7:0]   to_q;
    logic         done_q;
    logic         err_q;
    logic         ovf_q;
    logic [7:0]   fifo_data_q;
    logic         fifo_we_q;
    logic         rx_done_q;

    logic       ctrl_wr;
    logic       arm_req;
    logic       abort_req;
    logic       busy;
    logic       edge_a;
    logic       edge_b;
    logic       any_edge;
    logic       clash;
    logic       timeout_hit;
    logic       shift_en;
    logic       data_bit;
    logic [7:0] shift_d;
    logic [7:0] status;
    logic       unused_wdata;

    assign ctrl_wr   = cs & we;
    assign arm_req   = ctrl_wr & regdata_write[INCTRL_ARM];
    assign abort_req = ctrl_wr & regdata_write[INCTRL_ABORT];
    assign unused_wdata = ^regdata_write[7:2];

    assign busy     = state_is_busy(state_q);
    assign edge_a   = a_rise | a_fall;
    assign edge_b   = b_rise | b_fall;
    assign any_edge = edge_a | edge_b;
    assign clash    = edge_a & edge_b;

    // Down-counter reaches its terminal count on the last allowed tick
    assign timeout_hit = tick & ~any_edge & (to_q == 8'd1);

    assign shift_en = ((state_q == ST_DATA_A) & a_fall) | ((state_q == ST_DATA_B) & b_fall);
    assign data_bit = (state_q == ST_DATA_A) ? b_level : a_level;
    assign shift_d  = {shift_q[6:0], data_bit};

    // Status word as seen on the shared register read bus
    always_comb begin
        status               = '0;
        status[INCTRL_ARMED] = (state_q != ST_IDLE);
        status[INCTRL_BUSY]  = busy;
        status[INCTRL_DONE]  = done_q;
        status[INCTRL_ERR]   = err_q;
        status[INCTRL_OVF]   = ovf_q;
    end

    // Receiver FSM, byte assembly and registered FIFO/done outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            startcnt_q  <= '0;
            endcnt_q    <= '0;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            to_q        <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            fifo_data_q <= '0;
            fifo_we_q   <= 1'b0;
            rx_done_q   <= 1'b0;
        end else begin
            fifo_we_q <= 1'b0;
            rx_done_q <= 1'b0;

            if (abort_req) begin
                state_q <= ST_IDLE;
                done_q  <= 1'b0;
                err_q   <= 1'b0;
                ovf_q   <= 1'b0;
            end else if (busy && (clash || timeout_hit)) begin
                err_q   <= 1'b1;
                state_q <= ST_IDLE;
            end else begin
                if (any_edge) begin
                    to_q <= TIMEOUT_TICKS;
                end else if (tick && (to_q != 8'd0)) begin
                    to_q <= to_q - 8'd1;
                end

                if (shift_en) begin
                    shift_q  <= shift_d;
                    bitcnt_q <= bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        if (fifo_free != 8'd0) begin
                            fifo_data_q <= shift_d;
                            fifo_we_q   <= 1'b1;
                        end else begin
                            ovf_q <= 1'b1;
                        end
                    end
                end

                case (state_q)
                    ST_IDLE: begin
                        if (arm_req) begin
                            state_q <= ST_WAIT_START;
                            done_q  <= 1'b0;
                            err_q   <= 1'b0;
                            ovf_q   <= 1'b0;
                        end
                    end
                    ST_WAIT_START: begin
                        if (a_fall && b_level) begin
                            state_q    <= ST_START;
                            startcnt_q <= '0;
                        end
                    end
                    ST_START: begin
                        if (a_rise) begin
                            if (startcnt_q == START_PULSES) begin
                                state_q  <= ST_DATA_A;
                                bitcnt_q <= '0;
                                shift_q  <= '0;
                            end else begin
                                err_q   <= 1'b1;
                                state_q <= ST_IDLE;
                            end
                        end else if (b_fall && !a_level && (startcnt_q != 3'd7)) begin
                            startcnt_q <= startcnt_q + 3'd1;
                        end
                    end
                    ST_DATA_A: begin
                        if (a_fall) begin
                            state_q <= ST_DATA_B;
                        end else if (b_fall && a_level) begin
                            state_q  <= ST_END;
                            endcnt_q <= '0;
                        end
                    end
                    ST_DATA_B: begin
                        if (b_fall) begin
                            state_q <= ST_DATA_A;
                        end
                    end
                    ST_END: begin
                        if (b_rise) begin
                            if ((endcnt_q == END_PULSES) && (bitcnt_q == 3'd0)) begin
                                done_q    <= 1'b1;
                                rx_done_q <= 1'b1;
                            end else begin
                                err_q <= 1'b1;
                            end
                            state_q <= ST_IDLE;
                        end else if (a_fall && !b_level && (endcnt_q != 2'd3)) begin
                            endcnt_q <= endcnt_q + 2'd1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign regdata_read = (cs && !we) ? status : 8'hzz;
    assign fifo_data    = fifo_data_q;
    assign fifo_we      = fifo_we_q;
    assign rx_done      = rx_done_q;

endmodule

// File: tb/tb_maple_in.sv
// Bench for maple_in: drives Maple frames at line level and compares pushed
// bytes, done pulses and INCTRL status against a frame-level reference model.
module tb_maple_in;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       in_p1 = 1'b1;
    logic       in_p5 = 1'b1;
    logic       cs = 1'b0;
    logic       we = 1'b0;
    wire  [7:0] regdata_read;
    logic [7:0] regdata_write = 8'h00;
    logic [7:0] fifo_data;
    logic       fifo_we;
    logic [7:0] fifo_free = 8'd8;
    logic       rx_done;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] push_q[$];
    int         done_cnt = 0;
    int         tick_cnt = 0;
    logic [7:0] fr_bytes[4];
    logic [7:0] fr_free[4];

    maple_in dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .in_p1        (in_p1),
        .in_p5        (in_p5),
        .cs           (cs),
        .we           (we),
        .regdata_read (regdata_read),
        .regdata_write(regdata_write),
        .fifo_data    (fifo_data),
        .fifo_we      (fifo_we),
        .fifo_free    (fifo_free),
        .rx_done      (rx_done)
    );

    always #5 clk = ~clk;

    // Tick strobe: one cycle in four
    initial begin
        forever begin
            repeat (3) @(posedge clk);
            #1 tick = 1'b1;
            @(posedge clk);
            #1 tick = 1'b0;
        end
    end

    // Scoreboard capture, sampled away from the active edge
    always @(negedge clk) begin
        if (fifo_we) push_q.push_back(fifo_data);
        if (rx_done) done_cnt++;
        if (tick) tick_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic set_p1(input logic v);
        in_p1 = v;
        step();
    endtask

    task automatic set_p5(input logic v);
        in_p5 = v;
        step();
    endtask

    task automatic reg_wr(input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1;
        we = 1'b1;
        regdata_write = d;
        @(posedge clk);
        #1;
        cs = 1'b0;
        we = 1'b0;
        regdata_write = 8'h00;
    endtask

    task automatic rd_status(output logic [7:0] v);
        cs = 1'b1;
        we = 1'b0;
        #1;
        v = regdata_read;
        cs = 1'b0;
        #1;
    endtask

    task automatic idle_lines();
        if (!in_p1) set_p1(1'b1);
        if (!in_p5) set_p5(1'b1);
    endtask

    // Start: SDCKA falls, n SDCKB falls (SDCKB left low), SDCKA rises
    task automatic send_start(input int n);
        set_p1(1'b0);
        for (int i = 0; i < n; i++) begin
            set_p5(1'b0);
            if (i < n - 1) set_p5(1'b1);
        end
        set_p1(1'b1);
    endtask

    // Alternating phases, MSB first; entered and left with SDCKB low
    task automatic send_bits(input int nbits);
        for (int j = 0; j < nbits; j++) begin
            logic [7:0] cur;
            logic       b;
            cur = fr_bytes[j / 8];
            b   = cur[7 - (j % 8)];
            if (j % 8 == 0) fifo_free = fr_free[j / 8];
            if (j % 2 == 0) begin
                if (!in_p1) set_p1(1'b1);
                if (b) set_p5(1'b1);
                set_p1(1'b0);
            end else begin
                if (b) set_p1(1'b1);
                if (!in_p5) set_p5(1'b1);
                set_p5(1'b0);
            end
        end
    endtask

    // End: SDCKB falls with SDCKA high, n SDCKA falls, SDCKB rises
    task automatic send_end(input int n);
        if (!in_p1) set_p1(1'b1);
        set_p5(1'b1);
        set_p5(1'b0);
        for (int i = 0; i < n; i++) begin
            set_p1(1'b0);
            if (i < n - 1) set_p1(1'b1);
        end
        set_p5(1'b1);
        set_p1(1'b1);
    endtask

    // Send one frame and compare with the frame-level model
    task automatic run_frame(input int ns, input int nbytes, input bit partial, input int ne,
                             input string tag);
        logic [7:0] s;
        logic [7:0] exp_q[$];
        logic [7:0] exp_status;
        bit         ovf;
        bit         ok;
        int         nbits;

        idle_lines();
        fifo_free = 8'd8;
        push_q.delete();
        done_cnt = 0;
        reg_wr(8'h01);
        rd_status(s);
        check_eq({tag, "_armed"}, s, 8'h01);

        nbits = nbytes * 8 + (partial ? 4 : 0);
        send_start(ns);
        send_bits(nbits);
        send_end(ne);
        step();
        fifo_free = 8'd8;

        ovf = 1'b0;
        if (ns == 4) begin
            for (int i = 0; i < nbytes; i++) begin
                if (fr_free[i] != 8'd0) exp_q.push_back(fr_bytes[i]);
                else ovf = 1'b1;
            end
        end
        ok = (ns == 4) && !partial && (ne == 2);
        exp_status = (ovf ? 8'h10 : 8'h00) | (ok ? 8'h04 : 8'h08);

        rd_status(s);
        check_eq({tag, "_status"}, s, exp_status);
        check_eq({tag, "_npush"}, push_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < push_q.size(); i++)
            check_eq($sformatf("%s_byte%0d", tag, i), push_q[i], exp_q[i]);
        check_eq({tag, "_rxdone"}, done_cnt, ok ? 1 : 0);
    endtask

    initial begin
        logic [7:0] s;
        int         budget;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rd_status(s);
        check_eq("rst_status", s, 8'h00);
        check_eq("rst_fifo_we", fifo_we, 1'b0);
        check_eq("rst_fifo_data", fifo_data, 8'h00);
        check_eq("rst_rx_done", rx_done, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // Nominal frame
        fr_bytes[0] = 8'hA5; fr_bytes[1] = 8'h01;
        fr_free[0]  = 8'd8;  fr_free[1]  = 8'd8;
        run_frame(4, 2, 1'b0, 2, "nominal");

        // Bad start count, then ABORT clears the error flag
        fr_bytes[0] = 8'h3C; fr_free[0] = 8'd8;
        run_frame(3, 1, 1'b0, 2, "badstart");
        reg_wr(8'h02);
        rd_status(s);
        check_eq("abort_clears", s, 8'h00);

        // Partial byte: 12 bits then end
        fr_bytes[0] = 8'($urandom); fr_bytes[1] = 8'($urandom);
        fr_free[0]  = 8'd8;         fr_free[1]  = 8'd8;
        run_frame(4, 1, 1'b1, 2, "partial");

        // Overflow on the second byte
        fr_bytes[0] = 8'($urandom); fr_bytes[1] = 8'($urandom);
        fr_free[0]  = 8'd8;         fr_free[1]  = 8'd0;
        run_frame(4, 2, 1'b0, 2, "overflow");

        // ARM and ABORT together: ABORT wins, flags cleared
        reg_wr(8'h03);
        rd_status(s);
        check_eq("arm_abort", s, 8'h00);

        // Randomized frames
        for (int k = 0; k < 10; k++) begin
            int rs, re, ns, ne, nb;
            bit part;
            rs = $urandom_range(0, 5);
            re = $urandom_range(0, 5);
            ns = (rs == 0) ? 3 : (rs == 1) ? 5 : 4;
            ne = (re == 0) ? 1 : (re == 1) ? 3 : 2;
            nb = $urandom_range(0, 3);
            part = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 4; i++) begin
                fr_bytes[i] = 8'($urandom);
                fr_free[i]  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            end
            run_frame(ns, nb, part, ne, $sformatf("rand%0d", k));
        end

        // Timeout with frozen lines; ARM during a frame is ignored
        idle_lines();
        reg_wr(8'h01);
        send_start(4);
        tick_cnt = 0;
        reg_wr(8'h01);
        rd_status(s);
        check_eq("arm_ignored", s, 8'h03);
        budget = 0;
        while (tick_cnt < 190 && budget < 2000) begin
            @(posedge clk);
            budget++;
        end
        #1;
        check_eq("to_wait190", budget < 2000, 1'b1);
        rd_status(s);
        check_eq("to_early", s, 8'h03);
        budget = 0;
        s = 8'h00;
        while (budget < 2000) begin
            @(posedge clk);
            #1;
            rd_status(s);
            budget++;
            if (s[3]) break;
        end
        check_eq("to_err", s, 8'h08);
        check_eq("to_ticks", (tick_cnt >= 198) && (tick_cnt <= 201), 1'b1);
        idle_lines();

        // ABORT mid-frame
        push_q.delete();
        reg_wr(8'h01);
        send_start(4);
        fr_bytes[0] = 8'hFF; fr_free[0] = 8'd8;
        send_bits(5);
        reg_wr(8'h02);
        rd_status(s);
        check_eq("abort_mid", s, 8'h00);
        send_bits(4);
        idle_lines();
        check_eq("abort_npush", push_q.size(), 0);

        // Reset mid-frame
        push_q.delete();
        done_cnt = 0;
        reg_wr(8'h01);
        send_start(4);
        fr_bytes[0] = 8'h5A; fr_free[0] = 8'd8;
        send_bits(6);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("midrst_fifo_we", fifo_we, 1'b0);
        check_eq("midrst_fifo_data", fifo_data, 8'h00);
        rd_status(s);
        check_eq("midrst_status", s, 8'h00);
        idle_lines();
        @(negedge clk);
        rst = 1'b1;
        step();
        rd_status(s);
        check_eq("postrst_status", s, 8'h00);
        check_eq("postrst_npush", push_q.size(), 0);
        check_eq("postrst_rxdone", done_cnt, 0);

        // Receiver still works after the mid-frame reset
        fr_bytes[0] = 8'($urandom); fr_free[0] = 8'd8;
        run_frame(4, 1, 1'b0, 2, "postrst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
